// File: rtl/vga_framebuffer.sv
// Avalon-MM VGA controller with an on-chip RGB332 framebuffer and programmable background colour.
// Optional: define VGA_FB_DOUBLE_BUFFER_EN for front/back buffers swapped at vblank via CTRL bit0.
module vga_framebuffer #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       chipselect,
    input  logic       write,
    input  logic [3:0] address,
    input  logic [7:0] writedata,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_n,
    output logic       VGA_SYNC_n,
    output logic       frame_irq
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int PIXELS  = H_ACTIVE * V_ACTIVE;
`ifdef VGA_FB_DOUBLE_BUFFER_EN
    localparam int DEPTH   = 2 * PIXELS;
`else
    localparam int DEPTH   = PIXELS;
`endif
    localparam int AW      = $clog2(DEPTH);

    localparam logic [3:0] REG_BG_R = 4'd0;
    localparam logic [3:0] REG_BG_G = 4'd1;
    localparam logic [3:0] REG_BG_B = 4'd2;
    localparam logic [3:0] REG_X_HI = 4'd3;
    localparam logic [3:0] REG_X_LO = 4'd4;
    localparam logic [3:0] REG_Y_HI = 4'd5;
    localparam logic [3:0] REG_Y_LO = 4'd6;
    localparam logic [3:0] REG_DATA = 4'd7;

    logic          pix_en;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [7:0]    bg_r, bg_g, bg_b;
    logic [15:0]   x_pos, y_pos;
    logic [7:0]    mem [DEPTH];
    logic [7:0]    rd_data;
    logic          active_d1, hs_d1, vs_d1;
    logic          reg_wr, in_range, data_wr, vblank_start;
    logic          h_active, v_active, h_sync, v_sync;
    logic [AW-1:0] wr_pix, rd_pix, wr_addr, rd_addr;

    assign VGA_CLK    = pix_en;
    assign VGA_SYNC_n = 1'b0;

    assign h_active     = hcnt < HW'(H_ACTIVE);
    assign v_active     = vcnt < VW'(V_ACTIVE);
    assign h_sync       = (hcnt >= HW'(H_ACTIVE + H_FP)) && (hcnt < HW'(H_ACTIVE + H_FP + H_SYNC));
    assign v_sync       = (vcnt >= VW'(V_ACTIVE + V_FP)) && (vcnt < VW'(V_ACTIVE + V_FP + V_SYNC));
    assign vblank_start = pix_en && (hcnt == '0) && (vcnt == VW'(V_ACTIVE));

    assign reg_wr   = chipselect && write;
    assign in_range = (x_pos < 16'(H_ACTIVE)) && (y_pos < 16'(V_ACTIVE));
    assign data_wr  = reg_wr && (address == REG_DATA) && in_range;

    assign wr_pix = AW'(y_pos) * AW'(H_ACTIVE) + AW'(x_pos);
    assign rd_pix = (h_active && v_active) ? AW'(vcnt) * AW'(H_ACTIVE) + AW'(hcnt) : '0;

`ifdef VGA_FB_DOUBLE_BUFFER_EN
    logic front_sel, swap_pending;

    // Buffer 0 lives at offset 0, buffer 1 at offset PIXELS; writes target the non-displayed one.
    assign wr_addr = front_sel ? wr_pix : wr_pix + AW'(PIXELS);
    assign rd_addr = front_sel ? rd_pix + AW'(PIXELS) : rd_pix;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            if (vblank_start && swap_pending)
                front_sel <= ~front_sel;
            if (reg_wr && (address == 4'd8) && writedata[0])
                swap_pending <= 1'b1;
            else if (vblank_start)
                swap_pending <= 1'b0;
        end
    end
`else
    assign wr_addr = wr_pix;
    assign rd_addr = rd_pix;
`endif

    // NOTE: the pixel store and its read register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (data_wr)
            mem[wr_addr] <= writedata;
        rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pix_en <= 1'b0;
            hcnt   <= '0;
            vcnt   <= '0;
        end else begin
            pix_en <= ~pix_en;
            if (pix_en) begin
                if (hcnt == HW'(H_TOTAL - 1)) begin
                    hcnt <= '0;
                    vcnt <= (vcnt == VW'(V_TOTAL - 1)) ? '0 : vcnt + 1'b1;
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
            end
        end
    end

    // Two-stage output pipeline: stage 1 aligns sync/blank with the RAM read, stage 2 drives pins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            active_d1   <= 1'b0;
            hs_d1       <= 1'b1;
            vs_d1       <= 1'b1;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_n <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            frame_irq   <= 1'b0;
        end else begin
            active_d1   <= h_active && v_active;
            hs_d1       <= ~h_sync;
            vs_d1       <= ~v_sync;
            VGA_HS      <= hs_d1;
            VGA_VS      <= vs_d1;
            VGA_BLANK_n <= active_d1;
            frame_irq   <= vblank_start;
            if (!active_d1) begin
                VGA_R <= '0;
                VGA_G <= '0;
                VGA_B <= '0;
            end else if (rd_data == 8'h00) begin
                VGA_R <= bg_r;
                VGA_G <= bg_g;
                VGA_B <= bg_b;
            end else begin
                VGA_R <= {rd_data[7:5], rd_data[7:5], rd_data[7:6]};
                VGA_G <= {rd_data[4:2], rd_data[4:2], rd_data[4:3]};
                VGA_B <= {4{rd_data[1:0]}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bg_r  <= 8'h00;
            bg_g  <= 8'h00;
            bg_b  <= 8'h80;
            x_pos <= '0;
            y_pos <= '0;
        end else if (reg_wr) begin
            case (address)
                REG_BG_R: bg_r <= writedata;
                REG_BG_G: bg_g <= writedata;
                REG_BG_B: bg_b <= writedata;
                REG_X_HI: x_pos[15:8] <= writedata;
                REG_X_LO: x_pos[7:0]  <= writedata;
                REG_Y_HI: y_pos[15:8] <= writedata;
                REG_Y_LO: y_pos[7:0]  <= writedata;
                REG_DATA: begin
                    if (in_range) begin
                        if (x_pos == 16'(H_ACTIVE - 1)) begin
                            x_pos <= '0;
                            y_pos <= (y_pos == 16'(V_ACTIVE - 1)) ? '0 : y_pos + 16'd1;
                        end else begin
                            x_pos <= x_pos + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_framebuffer.sv
// Randomised self-checking bench for vga_framebuffer on a reduced 16x8 raster.
// Pins are predicted from the clock count since reset and a software image of the framebuffer.
module tb_vga_framebuffer;
    localparam int HA  = 16, HFP = 2, HSY = 4, HBP = 2;
    localparam int VA  = 8,  VFP = 1, VSY = 2, VBP = 1;
    localparam int HT  = HA + HFP + HSY + HBP;
    localparam int VT  = VA + VFP + VSY + VBP;
    localparam int F   = HT * VT;        // pixel slots per frame; one frame lasts 2*F clocks
    localparam int NPIX = HA * VA;

    localparam logic [3:0] A_BG_R = 4'd0, A_BG_G = 4'd1, A_BG_B = 4'd2;
    localparam logic [3:0] A_X_HI = 4'd3, A_X_LO = 4'd4, A_Y_HI = 4'd5, A_Y_LO = 4'd6;
    localparam logic [3:0] A_DATA = 4'd7, A_CTRL = 4'd8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       chipselect = 1'b0;
    logic       write = 1'b0;
    logic [3:0] address = '0;
    logic [7:0] writedata = '0;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n, frame_irq;

    vga_framebuffer #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .write(write),
        .address(address), .writedata(writedata),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_CLK(VGA_CLK),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_n(VGA_BLANK_n),
        .VGA_SYNC_n(VGA_SYNC_n), .frame_irq(frame_irq)
    );

    always #5 clk = ~clk;

    // Clock edges since the last edge that sampled reset low (that edge is n = 0).
    int unsigned n = 0;
    always @(posedge clk) begin
        if (!reset_n) n <= 0;
        else          n <= n + 1;
    end

    // Reference state.
    logic [7:0]  fb [2][NPIX];
    logic [7:0]  bg_r = 8'h00, bg_g = 8'h00, bg_b = 8'h80;
    logic [15:0] cx = '0, cy = '0;
    int          front = 0;
    bit          pending = 1'b0;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int back_buf();
`ifdef VGA_FB_DOUBLE_BUFFER_EN
        return 1 - front;
`else
        return 0;
`endif
    endfunction

    function automatic logic [23:0] colour(input logic [7:0] p);
        if (p == 8'h00) return {bg_r, bg_g, bg_b};
        return {p[7:5], p[7:5], p[7:6], p[4:2], p[4:2], p[4:3], {4{p[1:0]}}};
    endfunction

    // Pins after edge nn show the raster slot reached by the counters two edges earlier;
    // the counters step one slot every second edge, starting from slot 0 at the reset edge.
    task automatic expect_pins(input int unsigned nn, output logic [23:0] rgb,
                               output logic hs, output logic vs, output logic blank);
        int p, h, v;
        bit act;
        if (nn < 2) begin
            rgb = '0; hs = 1'b1; vs = 1'b1; blank = 1'b0;
            return;
        end
        p   = int'((nn - 2) / 2) % F;
        h   = p % HT;
        v   = p / HT;
        act = (h < HA) && (v < VA);
        hs    = !((h >= HA + HFP) && (h < HA + HFP + HSY));
        vs    = !((v >= VA + VFP) && (v < VA + VFP + VSY));
        blank = act;
        rgb   = act ? colour(fb[front][v * HA + h]) : 24'h0;
    endtask

    // frame_irq follows the edge where the counters sat on slot (0, VA) with pix_en high.
    function automatic logic exp_irq(input int unsigned nn);
        if (nn < 1) return 1'b0;
        return ((nn - 1) % 2 == 1) && (int'((nn - 1) / 2) % F == VA * HT);
    endfunction

    task automatic model_wr(input logic [3:0] a, input logic [7:0] d);
        int idx;
        case (a)
            A_BG_R: bg_r = d;
            A_BG_G: bg_g = d;
            A_BG_B: bg_b = d;
            A_X_HI: cx[15:8] = d;
            A_X_LO: cx[7:0]  = d;
            A_Y_HI: cy[15:8] = d;
            A_Y_LO: cy[7:0]  = d;
            A_DATA: begin
                if (int'(cx) < HA && int'(cy) < VA) begin
                    idx = int'(cy) * HA + int'(cx);
                    fb[back_buf()][idx] = d;
                    idx = (idx + 1) % NPIX;
                    cx  = 16'(idx % HA);
                    cy  = 16'(idx / HA);
                end
            end
`ifdef VGA_FB_DOUBLE_BUFFER_EN
            A_CTRL: if (d[0]) pending = 1'b1;
`endif
            default: ;
        endcase
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        model_wr(a, d);
    endtask

    task automatic set_cursor(input int x, input int y);
        bus_wr(A_X_HI, 8'(x >> 8));
        bus_wr(A_X_LO, 8'(x));
        bus_wr(A_Y_HI, 8'(y >> 8));
        bus_wr(A_Y_LO, 8'(y));
    endtask

    task automatic wait_irq(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 2 * F + 8; i++) begin
            @(negedge clk);
            if (frame_irq) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, seen, 1'b1);
        if (seen && pending) begin
            front   = 1 - front;
            pending = 1'b0;
        end
    endtask

    // Makes the most recent writes visible: a no-op with a single buffer.
    task automatic publish();
`ifdef VGA_FB_DOUBLE_BUFFER_EN
        bus_wr(A_CTRL, 8'h01);
        wait_irq("publish_irq");
`endif
    endtask

    task automatic pixel_at(input int x, input int y, output logic [23:0] rgb);
        bit found = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2 * F + 8; i++) begin
            @(negedge clk);
            if (n >= 2 && int'((n - 2) / 2) % F == y * HT + x) begin
                found = 1'b1;
                break;
            end
        end
        rgb = found ? {VGA_R, VGA_G, VGA_B} : 24'hxxxxxx;
    endtask

    task automatic frame_compare(input string tag, input bit timing);
        int mism = 0, hs_line = 0, hs_low = 0, vs_low = 0, blank_hi = 0, irqs = 0;
        logic [23:0] e_rgb;
        logic e_hs, e_vs, e_bl, e_irq;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2 * F; i++) begin
            @(negedge clk);
            expect_pins(n, e_rgb, e_hs, e_vs, e_bl);
            e_irq = exp_irq(n);
            if ({VGA_R, VGA_G, VGA_B} !== e_rgb || VGA_HS !== e_hs || VGA_VS !== e_vs ||
                VGA_BLANK_n !== e_bl || frame_irq !== e_irq || VGA_CLK !== 1'(n % 2) ||
                VGA_SYNC_n !== 1'b0) begin
                if (mism == 0)
                    $display("  %s first divergence n=%0d rgb=%h/%h hs=%b/%b vs=%b/%b blank=%b/%b irq=%b/%b",
                             tag, n, {VGA_R, VGA_G, VGA_B}, e_rgb, VGA_HS, e_hs, VGA_VS, e_vs,
                             VGA_BLANK_n, e_bl, frame_irq, e_irq);
                mism++;
            end
            if (i < 2 * HT && !VGA_HS) hs_line++;
            if (!VGA_HS)     hs_low++;
            if (!VGA_VS)     vs_low++;
            if (VGA_BLANK_n) blank_hi++;
            if (frame_irq)   irqs++;
        end
        check({tag, "_mismatches"}, mism, 0);
        if (timing) begin
            check("hs_low_per_line", hs_line, 2 * HSY);
            check("hs_low_per_frame", hs_low, 2 * HSY * VT);
            check("vs_low_per_frame", vs_low, 2 * VSY * HT);
            check("blank_high_per_frame", blank_hi, 2 * HA * VA);
            check("irqs_per_frame", irqs, 1);
        end
    endtask

    task automatic fill_random();
        set_cursor(0, 0);
        for (int i = 0; i < NPIX; i++)
            bus_wr(A_DATA, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [23:0] rgb;
        int unsigned irq_a, sel;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_hs", VGA_HS, 1'b1);
        check("rst_vs", VGA_VS, 1'b1);
        check("rst_blank", VGA_BLANK_n, 1'b0);
        check("rst_rgb", {VGA_R, VGA_G, VGA_B}, 24'h0);
        check("rst_irq", frame_irq, 1'b0);
        check("rst_vga_clk", VGA_CLK, 1'b0);
        reset_n = 1'b1;

        // Known image, frame period and sync widths.
        fill_random();
        check("fill_cursor_wrapped", {cx, cy}, 32'h0);
`ifdef VGA_FB_DOUBLE_BUFFER_EN
        publish();
        fill_random();
`endif
        wait_irq("irq_first");
        irq_a = n;
        wait_irq("irq_second");
        check("irq_period_clk", n - irq_a, 2 * F);
        frame_compare("frame_fill", 1'b1);

        // Randomised register traffic, including ignored addresses and out-of-range cursors.
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0: bus_wr(A_X_LO, 8'($urandom_range(0, HA + 1)));
                1: bus_wr(A_Y_LO, 8'($urandom_range(0, VA + 1)));
                2: bus_wr(A_X_HI, ($urandom_range(0, 5) == 0) ? 8'h01 : 8'h00);
                3: bus_wr(A_Y_HI, ($urandom_range(0, 5) == 0) ? 8'h01 : 8'h00);
                4: bus_wr(A_BG_R, 8'($urandom));
                5: bus_wr(4'($urandom_range(9, 15)), 8'($urandom));
                default: bus_wr(A_DATA, 8'($urandom));
            endcase
        end
        publish();
        frame_compare("frame_random", 1'b0);

        // Directed colour mapping and cursor wrap.
        bus_wr(A_BG_R, 8'h00);
        bus_wr(A_BG_G, 8'h00);
        bus_wr(A_BG_B, 8'h80);
        set_cursor(0, 0);
        bus_wr(A_DATA, 8'hE0);
        bus_wr(A_DATA, 8'h00);
        publish();
        pixel_at(0, 0, rgb);
        check("px_0_0_red", rgb, 24'hFF0000);
        pixel_at(1, 0, rgb);
        check("px_1_0_bg", rgb, 24'h000080);

        set_cursor(HA - 1, 5);
        bus_wr(A_DATA, 8'h03);
        bus_wr(A_DATA, 8'h1C);
        publish();
        pixel_at(HA - 1, 5, rgb);
        check("px_line_end_blue", rgb, 24'h0000FF);
        pixel_at(0, 6, rgb);
        check("px_line_wrap_green", rgb, 24'h00FF00);

        set_cursor(HA - 1, VA - 1);
        bus_wr(A_DATA, 8'h55);
        bus_wr(A_DATA, 8'hAA);
        publish();
        pixel_at(HA - 1, VA - 1, rgb);
        check("px_last", rgb, 24'h49B655);
        pixel_at(0, 0, rgb);
        check("px_frame_wrap", rgb, 24'hB649AA);

        // Out-of-range cursor drops data and does not move.
        set_cursor(HA, 0);
        bus_wr(A_DATA, 8'hFF);
        bus_wr(A_DATA, 8'hFF);
        check("oob_cursor_held", int'(cx), HA);
        frame_compare("frame_oob", 1'b0);

        bus_wr(A_BG_G, 8'h40);
        pixel_at(1, 0, rgb);
        check("px_bg_green", rgb, 24'h004080);
        frame_compare("frame_bg", 1'b0);

`ifdef VGA_FB_DOUBLE_BUFFER_EN
        wait_irq("db_sync_irq");
        set_cursor(0, 0);
        bus_wr(A_DATA, 8'hE0);
        pixel_at(0, 0, rgb);
        check("db_hidden", rgb, colour(fb[front][0]));
        wait_irq("db_align_irq");
        bus_wr(A_CTRL, 8'h01);
        bus_wr(A_CTRL, 8'h01);
        wait_irq("db_swap_irq");
        pixel_at(0, 0, rgb);
        check("db_swapped_red", rgb, 24'hFF0000);
        set_cursor(0, 0);
        bus_wr(A_DATA, 8'h1C);
        pixel_at(0, 0, rgb);
        check("db_still_red", rgb, 24'hFF0000);
        frame_compare("frame_db", 1'b0);
`endif

        // Mid-line reset while the counters sit at (10,2).
        for (int i = 0; i < 2 * F + 4; i++) begin
            @(negedge clk);
            if (int'(n / 2) % F == 2 * HT + 10) break;
        end
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_hs", VGA_HS, 1'b1);
        check("midrst_blank", VGA_BLANK_n, 1'b0);
        check("midrst_rgb", {VGA_R, VGA_G, VGA_B}, 24'h0);
        reset_n = 1'b1;
        bg_r = 8'h00; bg_g = 8'h00; bg_b = 8'h80;
        cx = '0; cy = '0; front = 0; pending = 1'b0;
        // Counters reach the sync start 2*(HA+HFP) edges after reset; pins follow 2 clocks later.
        for (int i = 0; i < 4 * HT; i++) begin
            @(negedge clk);
            if (!VGA_HS) break;
        end
        check("midrst_first_hs_low_edge", n, 2 * (HA + HFP) + 2);
        frame_compare("frame_after_reset", 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
